// File: rtl/ram_port_b_arbiter.sv
// ram_port_b_arbiter: round-robin sharing of operand RAM port B among NREQ
// internal requesters. The grant (ack) is combinational and the access is
// captured into the registered port-B outputs on the same edge, so one
// access can issue every cycle. Read tags ride a (1+RAM_LAT)-deep pipeline,
// which routes each read's data back to the requester that issued it.
//
// Optional feature: define ORI_ARB_LOCK_EN to add the lock[] input. A
// granted requester holding lock becomes owner and keeps exclusive access
// until its lock drops.
module ram_port_b_arbiter #(
  parameter int DATA    = 256,
  parameter int ADDR    = 5,
  parameter int NREQ    = 3,
  parameter int RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_en,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*(ADDR+1)-1:0] addr,
  input  logic [NREQ*DATA-1:0]     wdata,
`ifdef ORI_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA-1:0]          rdata,
  output logic                     b_w,
  output logic [ADDR:0]            b_adbus,
  output logic [DATA-1:0]          b_data_in,
  input  logic [DATA-1:0]          b_data_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win;
  logic            hit;
  logic            rd_push;
  logic [NREQ-1:0] tag_pipe [0:RAM_LAT];

`ifdef ORI_ARB_LOCK_EN
  logic            own_vld;
  logic [PW-1:0]   own_idx;
  logic            own_hold;

  // The owner keeps exclusive eligibility only while its lock is still high;
  // in the release cycle everyone competes again from the pointer.
  assign own_hold = own_vld && lock[own_idx];

  // Eligibility mask: only the owner while it holds, otherwise all requesters.
  always_comb begin
    elig = '0;
    if (arb_en) begin
      if (own_hold) elig = req & (NREQ'(1) << own_idx);
      else          elig = req;
    end
  end

  // Ownership register: taken on a locked grant, dropped when lock falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_vld <= 1'b0;
      own_idx <= '0;
    end else if (hit && lock[win]) begin
      own_vld <= 1'b1;
      own_idx <= win;
    end else if (own_vld && !lock[own_idx]) begin
      own_vld <= 1'b0;
    end
  end
`else
  // Eligibility mask: pure round-robin over the raw requests.
  always_comb begin
    elig = arb_en ? req : '0;
  end
`endif

  // Round-robin search starting at the pointer and wrapping past NREQ-1.
  always_comb begin
    int idx;
    grant = '0;
    win   = '0;
    hit   = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && elig[idx]) begin
        hit = 1'b1;
        win = PW'(idx);
      end
    end
    if (hit) grant[win] = 1'b1;
  end

  assign ack     = rst_n ? grant : '0;
  assign rd_push = hit && !we[win];
  assign rvalid  = tag_pipe[RAM_LAT];
  assign rdata   = b_data_out;

  // Capture the winner's access into the port-B registers and advance the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_w       <= 1'b0;
      b_adbus   <= '0;
      b_data_in <= '0;
      ptr       <= '0;
    end else if (hit) begin
      b_w       <= we[win];
      b_adbus   <= addr[int'(win)*(ADDR+1) +: (ADDR+1)];
      b_data_in <= wdata[int'(win)*DATA +: DATA];
      ptr       <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
    end else begin
      b_w       <= 1'b0;
    end
  end

  // Read-tag pipeline: stage 0 is loaded at the grant edge, the last stage
  // lines up with the RAM's read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= RAM_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= rd_push ? grant : '0;
      for (int s = 1; s <= RAM_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Directed bench for ram_port_b_arbiter with a small registered RAM model
// on port B. Define ORI_ARB_LOCK_EN to also exercise the lock feature.
module tb_ram_port_b_arbiter;

  localparam int DATA = 256;
  localparam int ADDR = 5;
  localparam int NREQ = 3;

  logic                     clk;
  logic                     rst_n;
  logic                     arb_en;
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          we;
  logic [NREQ*(ADDR+1)-1:0] addr;
  logic [NREQ*DATA-1:0]     wdata;
`ifdef ORI_ARB_LOCK_EN
  logic [NREQ-1:0]          lock;
`endif
  logic [NREQ-1:0]          ack;
  logic [NREQ-1:0]          rvalid;
  logic [DATA-1:0]          rdata;
  logic                     b_w;
  logic [ADDR:0]            b_adbus;
  logic [DATA-1:0]          b_data_in;
  logic [DATA-1:0]          b_data_out;

  int checks = 0;
  int errors = 0;

  ram_port_b_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NREQ), .RAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .we(we),
    .addr(addr), .wdata(wdata),
`ifdef ORI_ARB_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .rvalid(rvalid), .rdata(rdata), .b_w(b_w), .b_adbus(b_adbus),
    .b_data_in(b_data_in), .b_data_out(b_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B RAM: one-cycle registered read, write on b_w. Initial word = addr + 0x40.
  logic [DATA-1:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = DATA'(i + 'h40);
  always @(posedge clk) begin
    if (b_w) mem[b_adbus] <= b_data_in;
    b_data_out <= mem[b_adbus];
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] r, input logic [2:0] w,
                       input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                       input logic [7:0] wd);
    arb_en = en;
    req    = r;
    we     = w;
    addr   = {a2, a1, a0};
    wdata  = {3{DATA'(wd)}};
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] r;
    logic [2:0] w;
    logic [5:0] a0, a1, a2;
    logic [7:0] wd;
    logic [2:0] e_ack;
    logic       e_bw;
    logic [5:0] e_ad;
    logic [2:0] e_rv;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vt [21];
  int   exp_idx;
  logic [2:0] exp_ack;

  initial begin
    vt[0]  = '{1'b0, 1'b1, 3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd0, 3'b000, 8'h00};
    vt[1]  = '{1'b0, 1'b1, 3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd0, 3'b000, 8'h00};
    vt[2]  = '{1'b1, 1'b1, 3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b001, 1'b0, 6'd0, 3'b000, 8'h00};
    vt[3]  = '{1'b1, 1'b1, 3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b010, 1'b0, 6'd1, 3'b000, 8'h00};
    vt[4]  = '{1'b1, 1'b1, 3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b100, 1'b0, 6'd2, 3'b001, 8'h41};
    vt[5]  = '{1'b1, 1'b1, 3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b001, 1'b0, 6'd3, 3'b010, 8'h42};
    vt[6]  = '{1'b1, 1'b1, 3'b000, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd1, 3'b100, 8'h43};
    vt[7]  = '{1'b1, 1'b1, 3'b000, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd1, 3'b001, 8'h41};
    vt[8]  = '{1'b1, 1'b1, 3'b010, 3'b010, 6'd1, 6'd6, 6'd6, 8'hA5, 3'b010, 1'b0, 6'd1, 3'b000, 8'h00};
    vt[9]  = '{1'b1, 1'b1, 3'b100, 3'b000, 6'd1, 6'd6, 6'd6, 8'hA5, 3'b100, 1'b1, 6'd6, 3'b000, 8'h00};
    vt[10] = '{1'b1, 1'b1, 3'b000, 3'b000, 6'd1, 6'd6, 6'd6, 8'h00, 3'b000, 1'b0, 6'd6, 3'b000, 8'h00};
    vt[11] = '{1'b1, 1'b1, 3'b000, 3'b000, 6'd1, 6'd6, 6'd6, 8'h00, 3'b000, 1'b0, 6'd6, 3'b100, 8'hA5};
    vt[12] = '{1'b1, 1'b0, 3'b011, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd6, 3'b000, 8'h00};
    vt[13] = '{1'b1, 1'b0, 3'b011, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd6, 3'b000, 8'h00};
    vt[14] = '{1'b1, 1'b0, 3'b011, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd6, 3'b000, 8'h00};
    vt[15] = '{1'b1, 1'b0, 3'b011, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd6, 3'b000, 8'h00};
    vt[16] = '{1'b1, 1'b1, 3'b011, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b001, 1'b0, 6'd6, 3'b000, 8'h00};
    vt[17] = '{1'b1, 1'b1, 3'b011, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b010, 1'b0, 6'd1, 3'b000, 8'h00};
    vt[18] = '{1'b1, 1'b1, 3'b000, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd2, 3'b001, 8'h41};
    vt[19] = '{1'b1, 1'b1, 3'b000, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd2, 3'b010, 8'h42};
    vt[20] = '{1'b1, 1'b1, 3'b000, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00, 3'b000, 1'b0, 6'd2, 3'b000, 8'h00};

`ifdef ORI_ARB_LOCK_EN
    lock = '0;
`endif
    rst_n = 1'b0;
    drive(1'b1, 3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00);

    // Table: reset, round-robin reads, write-then-read, arb_en low.
    for (int v = 0; v < 21; v++) begin
      rst_n = vt[v].rst;
      drive(vt[v].en, vt[v].r, vt[v].w, vt[v].a0, vt[v].a1, vt[v].a2, vt[v].wd);
      @(negedge clk);
      chk($sformatf("vec%0d ack", v), DATA'(ack), DATA'(vt[v].e_ack));
      chk($sformatf("vec%0d b_w", v), DATA'(b_w), DATA'(vt[v].e_bw));
      chk($sformatf("vec%0d b_adbus", v), DATA'(b_adbus), DATA'(vt[v].e_ad));
      chk($sformatf("vec%0d rvalid", v), DATA'(rvalid), DATA'(vt[v].e_rv));
      if (vt[v].e_rv != 3'b000)
        chk($sformatf("vec%0d rdata", v), rdata, DATA'(vt[v].e_rd));
      next_cycle();
    end

    // Reset mid-operation: read from requester 1 (pointer is at 2), then reset.
    drive(1'b1, 3'b010, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00);
    @(negedge clk);
    chk("midrst ack", DATA'(ack), DATA'(3'b010));
    next_cycle();
    rst_n = 1'b0;
    drive(1'b1, 3'b000, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00);
    @(negedge clk);
    chk("midrst rvalid in reset", DATA'(rvalid), DATA'(3'b000));
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst rvalid after %0d", c), DATA'(rvalid), DATA'(3'b000));
      next_cycle();
    end
    drive(1'b1, 3'b111, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00);
    @(negedge clk);
    chk("midrst pointer", DATA'(ack), DATA'(3'b001));
    next_cycle();

    // arb_en dropped with a read in flight: no ack, read still returns.
    arb_en = 1'b0;
    @(negedge clk);
    chk("endrop ack", DATA'(ack), DATA'(3'b000));
    chk("endrop rvalid early", DATA'(rvalid), DATA'(3'b000));
    next_cycle();
    @(negedge clk);
    chk("endrop ack2", DATA'(ack), DATA'(3'b000));
    chk("endrop rvalid", DATA'(rvalid), DATA'(3'b001));
    chk("endrop rdata", rdata, DATA'(8'h41));
    next_cycle();

    // Fairness: all requesting continuously, pointer at 1.
    arb_en  = 1'b1;
    exp_idx = 1;
    for (int c = 0; c < 9; c++) begin
      exp_ack = 3'b001 << exp_idx;
      @(negedge clk);
      chk($sformatf("fair%0d ack", c), DATA'(ack), DATA'(exp_ack));
      exp_idx = (exp_idx + 1) % NREQ;
      next_cycle();
    end
    req = 3'b000;
    next_cycle();
    next_cycle();

`ifdef ORI_ARB_LOCK_EN
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    drive(1'b1, 3'b011, 3'b000, 6'd1, 6'd2, 6'd3, 8'h00);
    lock = 3'b001;
    @(negedge clk);
    chk("lock c1 ack", DATA'(ack), DATA'(3'b001));
    next_cycle();
    req = 3'b010;
    @(negedge clk);
    chk("lock owner idle ack", DATA'(ack), DATA'(3'b000));
    next_cycle();
    req = 3'b011;
    @(negedge clk);
    chk("lock c2 ack", DATA'(ack), DATA'(3'b001));
    next_cycle();
    @(negedge clk);
    chk("lock c3 ack", DATA'(ack), DATA'(3'b001));
    next_cycle();
    lock = 3'b000;
    @(negedge clk);
    chk("lock release ack", DATA'(ack), DATA'(3'b010));
    next_cycle();
    req = 3'b000;
    next_cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_b_arbiter.md
Name: ram_port_b_arbiter

Overview:
- Shares port B of the 256-bit dual-port operand RAM between NREQ internal requesters, e.g. the multiplier operand fetch, result writeback and reduction unit.
- Round-robin arbitration with a combinational acknowledge, so the block can issue one RAM access per cycle.
- RAM port-B outputs are registered; each read's data is returned to the requester that issued it, with a valid pulse.
- Port A stays with the external host and is not touched by this block.

Parameters:
- DATA, 256, RAM word width.
- ADDR, 5, RAM address MSB index; address width is ADDR+1 bits.
- NREQ, 3, number of requesters (2..8).
- RAM_LAT, 1, RAM read latency in cycles, from registered address to valid b_data_out.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- arb_en  input  1  arbitration enable; when low, no new grants are issued.
- req  input  NREQ  per-requester access request, level, held until acked.
- we  input  NREQ  per-requester write flag, qualified by req.
- addr  input  NREQ*(ADDR+1)  packed addresses; requester i is in slice i.
- wdata  input  NREQ*DATA  packed write data.
- ack  output  NREQ  one-hot grant; combinational; the access is captured at the same clock edge.
- rvalid  output  NREQ  one-hot read-return pulse.
- rdata  output  DATA  read data, valid when any rvalid bit is high.
- b_w  output  1  RAM port-B write enable, registered.
- b_adbus  output  ADDR+1  RAM port-B address, registered.
- b_data_in  output  DATA  RAM port-B write data, registered.
- b_data_out  input  DATA  RAM port-B read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - b_w=0, b_adbus=0, b_data_in=0.
  - rvalid=0; ack forced to 0 while rst_n is low.
  - Round-robin pointer = 0; read-tag pipeline cleared.
- Arbitration:
  - Each cycle with arb_en=1 and req!=0, grant the first requester with req high, searching from the pointer upward with wrap (pointer, pointer+1, ..., NREQ-1, 0, ...).
  - ack is one-hot for the winner; all other ack bits are 0.
  - At most one ack per cycle.
  - If arb_en=0 or req=0: ack=0, b_w registers 0, and b_adbus/b_data_in hold their previous values.
- Issue:
  - On the edge of an ack cycle, register b_w=we[i], b_adbus=addr slice i, b_data_in=wdata slice i.
  - Pointer becomes (i+1) mod NREQ.
  - Without an ack, the pointer is unchanged.
- Handshake:
  - A requester must keep req, we, addr and wdata stable until it sees ack.
  - In the cycle after ack it may present a new request or drop req.
  - A requester that keeps req high after ack is treated as a new request and enters round-robin again.
- Read return:
  - A granted read (we=0) pushes tag i into a (1+RAM_LAT)-deep shift pipeline.
  - rvalid[i] pulses for exactly 1 cycle, 1+RAM_LAT cycles after the ack cycle (2 cycles at default).
  - rdata=b_data_out in that cycle; rdata passes b_data_out through at all times.
  - Writes produce no rvalid.
  - Back-to-back reads produce back-to-back rvalid pulses in issue order.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,2,0,1,2,... with no starvation.
- arb_en dropped mid-stream: reads already issued still return their rvalid; no new ack.
- Reset mid-operation: in-flight reads are discarded, and no rvalid appears after rst_n is released.
- Same-address write then read on consecutive grants: the read returns the new data (RAM write-first ordering is the RAM's responsibility; the arbiter preserves issue order).

Optional Feature:
- Macro ORI_ARB_LOCK_EN enables the lock feature.
- With the macro defined:
  - An extra input lock [NREQ-1:0] is added.
  - If the granted requester has lock high on its ack cycle, it becomes owner.
  - While the owner's lock stays high, only the owner can be acked, including across cycles where its req is low; other requests wait.
  - Ownership is released in the first cycle the owner's lock is low. Arbitration resumes that same cycle, with the pointer at owner+1.
  - Reset clears ownership.
- Without the macro: the lock port is absent and arbitration is pure round-robin.

Test Plan:
- Reset check: hold rst_n=0 with req=3'b111 -> ack=0, b_w=0, b_adbus=0, rvalid=0; after release, the first grant goes to requester 0.
- All three requesters continuously requesting reads at addr 1/2/3 -> ack sequence 001,010,100,001... and b_adbus 1,2,3,1... one cycle later.
  - rvalid sequence follows 2 cycles after each ack, with the matching rdata.
- Requester 1 writes 0xA5 (zero-extended) to addr 6, then requester 2 reads addr 6 -> rvalid=3'b100 two cycles after the read ack, rdata=0xA5.
- arb_en=0 for 4 cycles with req=3'b011 -> ack=0 and b_w=0 throughout; on re-enable, ack goes to the requester at the pointer.
- Read acked, then rst_n pulsed low the next cycle -> no rvalid pulse after release; pointer is back at 0.
- ORI_ARB_LOCK_EN defined: requester 0 holds lock for 3 accesses while requester 1 requests -> requester 1 is not acked until the cycle lock[0] drops, then ack=3'b010.
